// File: rtl/frame_deserializer.sv
// Serial-to-byte frame receiver: hunts for SYNC_WORD, then delivers PAYLOAD_LEN bytes MSB first.
// Define PARITY_CHECK_EN to expect an even-parity bit after every payload byte.
module frame_deserializer #(
   parameter logic [7:0] SYNC_WORD   = 8'h7E,
   parameter int         PAYLOAD_LEN = 256,
   parameter int         LEN_W       = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_done,
   output logic       sync_locked
`ifdef PARITY_CHECK_EN
   ,
   output logic       parity_err
`endif
);

`ifdef PARITY_CHECK_EN
   localparam logic [3:0] LAST_BIT = 4'd8;
`else
   localparam logic [3:0] LAST_BIT = 4'd7;
`endif
   localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(PAYLOAD_LEN);

   typedef enum logic {HUNT, LOAD} state_e;

   state_e           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [3:0]       bitCnt_q, bitCnt_d;
   logic [LEN_W-1:0] byteCnt_q, byteCnt_d;
   logic [7:0]       byteOut_q, byteOut_d;
   logic             byteValid_q, byteValid_d;
   logic             frameDone_q, frameDone_d;
`ifdef PARITY_CHECK_EN
   logic             parityErr_q, parityErr_d;
`endif

   logic [7:0]       shifted;
   logic [LEN_W-1:0] byteCntInc;

   assign shifted    = {shift_q[6:0], bit_in};
   assign byteCntInc = byteCnt_q + LEN_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HUNT;
         shift_q     <= '0;
         bitCnt_q    <= '0;
         byteCnt_q   <= '0;
         byteOut_q   <= '0;
         byteValid_q <= 1'b0;
         frameDone_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         parityErr_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bitCnt_q    <= bitCnt_d;
         byteCnt_q   <= byteCnt_d;
         byteOut_q   <= byteOut_d;
         byteValid_q <= byteValid_d;
         frameDone_q <= frameDone_d;
`ifdef PARITY_CHECK_EN
         parityErr_q <= parityErr_d;
`endif
      end
   end

   // Only strobed bits move the datapath; pulse outputs fall back to 0 every cycle.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bitCnt_d    = bitCnt_q;
      byteCnt_d   = byteCnt_q;
      byteOut_d   = byteOut_q;
      byteValid_d = 1'b0;
      frameDone_d = 1'b0;
`ifdef PARITY_CHECK_EN
      parityErr_d = 1'b0;
`endif
      if (bit_valid) begin
         unique case (state_q)
            HUNT: begin
               shift_d = shifted;
               if (shifted == SYNC_WORD) begin
                  state_d   = LOAD;
                  shift_d   = '0;
                  bitCnt_d  = '0;
                  byteCnt_d = '0;
               end
            end
            LOAD: begin
               shift_d = shifted;
               if (bitCnt_q == LAST_BIT) begin
                  // Clearing here also leaves a clean register for hunting after the last byte.
                  shift_d     = '0;
                  bitCnt_d    = '0;
                  byteCnt_d   = byteCntInc;
                  byteValid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                  byteOut_d   = shift_q;
                  parityErr_d = ^{shift_q, bit_in};
`else
                  byteOut_d   = shifted;
`endif
                  if (byteCntInc == LEN_LAST) begin
                     frameDone_d = 1'b1;
                     state_d     = HUNT;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   assign byte_out    = byteOut_q;
   assign byte_valid  = byteValid_q;
   assign frame_done  = frameDone_q;
   assign sync_locked = (state_q == LOAD);
`ifdef PARITY_CHECK_EN
   assign parity_err  = parityErr_q;
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
// Bench for frame_deserializer: bit-level reference model checked every cycle plus directed literal checks.
// Honours PARITY_CHECK_EN the same way the design does.
module tb_frame_deserializer;

   localparam int LEN = 2;
`ifdef PARITY_CHECK_EN
   localparam int BPB = 9;
   localparam int PAR = 1;
`else
   localparam int BPB = 8;
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       reset;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_done;
   logic       sync_locked;
`ifdef PARITY_CHECK_EN
   logic       parity_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   frame_deserializer #(.SYNC_WORD(8'h7E), .PAYLOAD_LEN(LEN), .LEN_W(9)) dut (
      .clk(clk),
      .reset(reset),
      .bit_in(bit_in),
      .bit_valid(bit_valid),
      .byte_out(byte_out),
      .byte_valid(byte_valid),
      .frame_done(frame_done),
      .sync_locked(sync_locked)
`ifdef PARITY_CHECK_EN
      ,
      .parity_err(parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: the last 8 hunted bits form a number; payload bits are grouped per byte.
   int huntQ[$];
   int dataQ[$];
   int loading = 0;
   int nBytes = 0;
   int expByte = 0, expValid = 0, expDone = 0, expPerr = 0;

   task automatic modelReset();
      huntQ.delete();
      dataQ.delete();
      loading = 0;
      nBytes = 0;
      expByte = 0;
      expValid = 0;
      expDone = 0;
      expPerr = 0;
   endtask

   always @(posedge clk) begin
      int val;
      int ones;
      cyc++;
      expValid = 0;
      expDone = 0;
      expPerr = 0;
      if (!reset) begin
         modelReset();
      end else if (bit_valid) begin
         if (loading == 0) begin
            huntQ.push_back(int'(bit_in));
            if (huntQ.size() > 8) void'(huntQ.pop_front());
            val = 0;
            foreach (huntQ[i]) val = val * 2 + huntQ[i];
            if (val == 'h7E) begin
               loading = 1;
               nBytes = 0;
               dataQ.delete();
               huntQ.delete();
            end
         end else begin
            dataQ.push_back(int'(bit_in));
            if (dataQ.size() == BPB) begin
               val = 0;
               ones = 0;
               for (int i = 0; i < 8; i++) val = val * 2 + dataQ[i];
               for (int i = 0; i < BPB; i++) ones += dataQ[i];
               expByte = val;
               expValid = 1;
               expPerr = PAR * (ones % 2);
               nBytes++;
               dataQ.delete();
               if (nBytes == LEN) begin
                  expDone = 1;
                  loading = 0;
                  huntQ.delete();
               end
            end
         end
      end
   end

   int gotByte[$];
   int gotCyc[$];
   int gotDone[$];
   int gotPerr[$];

   always @(negedge clk) begin
      if (!reset) modelReset();
      checkOutput("byte_out", int'(byte_out), expByte);
      checkOutput("byte_valid", int'(byte_valid), expValid);
      checkOutput("frame_done", int'(frame_done), expDone);
      checkOutput("sync_locked", int'(sync_locked), loading);
`ifdef PARITY_CHECK_EN
      checkOutput("parity_err", int'(parity_err), expPerr);
`endif
      if (byte_valid) begin
         gotByte.push_back(int'(byte_out));
         gotCyc.push_back(cyc);
         gotDone.push_back(int'(frame_done));
`ifdef PARITY_CHECK_EN
         gotPerr.push_back(int'(parity_err));
`else
         gotPerr.push_back(0);
`endif
      end
   end

   function automatic int qAt(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clearCapture();
      gotByte.delete();
      gotCyc.delete();
      gotDone.delete();
      gotPerr.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobes one bit, then leaves 'gap' idle cycles with junk on bit_in.
   task automatic applyStimulus(input logic b, input int gap);
      bit_in = b;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in = 1'($urandom);
      idle(gap);
   endtask

   task automatic sendRaw(input logic [7:0] v, input int gap);
      for (int i = 7; i >= 0; i--) applyStimulus(v[i], gap);
   endtask

   task automatic sendByte(input logic [7:0] v, input int gap, input logic flip);
      sendRaw(v, gap);
`ifdef PARITY_CHECK_EN
      applyStimulus((^v) ^ flip, gap);
`else
      if (flip) bit_in = 1'b0;
`endif
   endtask

   initial begin
      logic [7:0] partial;
      reset = 1'b0;
      bit_in = 1'b0;
      bit_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset sync_locked", int'(sync_locked), 0);
      checkOutput("reset byte_out", int'(byte_out), 0);
      reset = 1'b1;
      idle(2);

      // Basic frame, continuous strobes; second byte carries a wrong parity bit when parity is on.
      clearCapture();
      sendRaw(8'h7E, 0);
      checkOutput("basic locked", int'(sync_locked), 1);
      sendByte(8'h48, 0, 1'b0);
      sendByte(8'h69, 0, 1'b1);
      idle(3);
      checkOutput("basic count", gotByte.size(), 2);
      checkOutput("basic byte0", qAt(gotByte, 0), 'h48);
      checkOutput("basic byte1", qAt(gotByte, 1), 'h69);
      checkOutput("basic done0", qAt(gotDone, 0), 0);
      checkOutput("basic done1", qAt(gotDone, 1), 1);
      checkOutput("basic spacing", qAt(gotCyc, 1) - qAt(gotCyc, 0), BPB);
      checkOutput("basic perr0", qAt(gotPerr, 0), 0);
      checkOutput("basic perr1", qAt(gotPerr, 1), PAR);
      checkOutput("basic unlocked", int'(sync_locked), 0);

      // Gapped strobes, one in three cycles.
      clearCapture();
      sendRaw(8'h7E, 2);
      sendByte(8'h48, 2, 1'b0);
      sendByte(8'h69, 2, 1'b0);
      idle(3);
      checkOutput("gap count", gotByte.size(), 2);
      checkOutput("gap byte0", qAt(gotByte, 0), 'h48);
      checkOutput("gap byte1", qAt(gotByte, 1), 'h69);
      checkOutput("gap spacing", qAt(gotCyc, 1) - qAt(gotCyc, 0), 3 * BPB);

      // Noise with a near-miss pattern before the true sync.
      clearCapture();
      sendRaw(8'hA5, 0);
      partial = 8'h3F;
      sendRaw(partial, 0);
      applyStimulus(1'b1, 0);
      checkOutput("noise no lock", int'(sync_locked), 0);
      checkOutput("noise no bytes", gotByte.size(), 0);
      sendRaw(8'h7E, 0);
      sendByte(8'hC3, 0, 1'b0);
      sendByte(8'h5A, 1, 1'b0);
      idle(3);
      checkOutput("noise count", gotByte.size(), 2);
      checkOutput("noise byte0", qAt(gotByte, 0), 'hC3);
      checkOutput("noise byte1", qAt(gotByte, 1), 'h5A);

      // Sync value inside the payload is plain data.
      clearCapture();
      sendRaw(8'h7E, 0);
      sendByte(8'h7E, 0, 1'b0);
      sendByte(8'h7E, 0, 1'b0);
      idle(2);
      checkOutput("sync-data count", gotByte.size(), 2);
      checkOutput("sync-data byte0", qAt(gotByte, 0), 'h7E);
      checkOutput("sync-data done1", qAt(gotDone, 1), 1);
      checkOutput("sync-data hunt", int'(sync_locked), 0);

      // Reset in the middle of the second byte.
      clearCapture();
      sendRaw(8'h7E, 0);
      sendByte(8'h48, 0, 1'b0);
      partial = 8'h69;
      for (int i = 7; i >= 4; i--) applyStimulus(partial[i], 0);
      reset = 1'b0;
      #1;
      checkOutput("abort byte_out", int'(byte_out), 0);
      checkOutput("abort locked", int'(sync_locked), 0);
      checkOutput("abort valid", int'(byte_valid), 0);
      idle(3);
      reset = 1'b1;
      sendByte(8'h69, 0, 1'b0);
      idle(2);
      checkOutput("abort count", gotByte.size(), 1);
      sendRaw(8'h7E, 0);
      sendByte(8'h12, 0, 1'b0);
      sendByte(8'h34, 0, 1'b0);
      idle(3);
      checkOutput("recover count", gotByte.size(), 3);
      checkOutput("recover byte", qAt(gotByte, 2), 'h34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
